// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access codes, FSM states
// and the byte-lane / extension helpers used by the top level.
package dmem_pkg;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } dmem_state_e;

    typedef struct packed {
        logic [3:0] second;
        logic [3:0] first;
    } lane_en_t;

    function automatic logic [2:0] size_of(input logic [1:0] code);
        logic [2:0] sz;
        case (code)
            2'b00:   sz = 3'd1;
            2'b01:   sz = 3'd2;
            2'b10:   sz = 3'd4;
            default: sz = 3'd0;
        endcase
        return sz;
    endfunction

    // Lanes past byte 3 of word N spill into the low lanes of word N+1.
    function automatic lane_en_t lane_enables(input logic [1:0] off, input logic [2:0] size);
        logic [7:0] base;
        logic [7:0] shifted;
        lane_en_t   res;
        case (size)
            3'd1:    base = 8'h01;
            3'd2:    base = 8'h03;
            3'd4:    base = 8'h0F;
            default: base = 8'h00;
        endcase
        shifted    = base << off;
        res.first  = shifted[3:0];
        res.second = shifted[7:4];
        return res;
    endfunction

    function automatic logic load_legal(input logic [2:0] code);
        logic ok;
        case (code)
            MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU: ok = 1'b1;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic store_legal(input logic [2:0] code);
        return ~code[2] & (code[1:0] != 2'b11);
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] code, input logic [31:0] v);
        logic [31:0] r;
        case (code)
            MASK_B:  r = {{24{v[7]}}, v[7:0]};
            MASK_H:  r = {{16{v[15]}}, v[15:0]};
            MASK_BU: r = {24'h000000, v[7:0]};
            MASK_HU: r = {16'h0000, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word RAM with synchronous read and per-byte write enables.
// Contents are deliberately not reset.
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores on dmem_bank, with
// misaligned accesses split over two cycles and the core stalled via ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        err
);

    dmem_state_e   state_q, state_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;
    logic          rsp_split_q, rsp_split_d;
    logic [1:0]    rsp_off_q, rsp_off_d;
    logic [2:0]    rsp_mask_q, rsp_mask_d;
    logic [31:0]   cap_q, cap_d;
    logic [31:0]   hold_q;

    logic          is_store_s;
    logic [1:0]    off_s;
    logic [AW-1:0] word_s;
    lane_en_t      lanes_s;
    logic          legal_s;
    logic          split_s;
    logic          accept_s;
    logic [63:0]   wshift_s;
    logic [AW-1:0] bank_addr_s;
    logic [3:0]    bank_we_s;
    logic [31:0]   bank_wdata_s;
    logic [31:0]   bank_rdata_s;
    logic [63:0]   pair_s;
    logic [63:0]   aligned_s;
    logic [31:0]   load_data_s;
    logic          unused_s;

    assign is_store_s = wr_en;
    assign off_s      = addr[1:0];
    assign word_s     = addr[AW+1:2];
    assign lanes_s    = lane_enables(off_s, size_of(mask[1:0]));
    assign legal_s    = is_store_s ? store_legal(mask) : load_legal(mask);
    assign split_s    = |lanes_s.second;
    assign accept_s   = (rd_en | wr_en) & (state_q == IDLE);
    assign wshift_s   = {32'h0000_0000, wdata} << {off_s, 3'b000};
    assign ready      = (state_q == IDLE);

    // Bank port steering: word N on accept, word N+1 (wrapping) in SPLIT.
    always_comb begin
        bank_addr_s  = word_s;
        bank_we_s    = 4'b0000;
        bank_wdata_s = wshift_s[31:0];
        if (state_q == SPLIT) begin
            bank_addr_s  = word_s + {{(AW-1){1'b0}}, 1'b1};
            bank_wdata_s = wshift_s[63:32];
            bank_we_s    = is_store_s ? lanes_s.second : 4'b0000;
        end else if (accept_s && is_store_s && legal_s) begin
            bank_we_s = lanes_s.first;
        end else begin
            bank_we_s = 4'b0000;
        end
    end

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_bank (
        .clk  (clk),
        .addr (bank_addr_s),
        .we   (bank_we_s),
        .wdata(bank_wdata_s),
        .rdata(bank_rdata_s)
    );

    // Next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (accept_s && legal_s && split_s) ? SPLIT : IDLE;
            SPLIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response bookkeeping; first-part bytes are captured while in SPLIT.
    always_comb begin
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        rsp_split_d = rsp_split_q;
        rsp_off_d   = rsp_off_q;
        rsp_mask_d  = rsp_mask_q;
        cap_d       = cap_q;
        if (state_q == SPLIT) begin
            rvalid_d    = ~is_store_s;
            rsp_split_d = 1'b1;
            rsp_off_d   = off_s;
            rsp_mask_d  = mask;
            cap_d       = bank_rdata_s;
        end else if (accept_s) begin
            err_d       = ~legal_s;
            rvalid_d    = ~is_store_s & ~(legal_s & split_s);
            rsp_split_d = 1'b0;
            rsp_off_d   = off_s;
            rsp_mask_d  = mask;
        end else begin
            rvalid_d = 1'b0;
        end
    end

    assign pair_s      = rsp_split_q ? {bank_rdata_s, cap_q} : {32'h0000_0000, bank_rdata_s};
    assign aligned_s   = pair_s >> {rsp_off_q, 3'b000};
    assign load_data_s = err_q ? 32'h0000_0000 : extend(rsp_mask_q, aligned_s[31:0]);
    assign rdata       = rvalid_q ? load_data_s : hold_q;
    assign rvalid      = rvalid_q;
    assign err         = err_q;
    assign unused_s    = ^{addr[31:AW+2], aligned_s[63:32]};

    // State and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rsp_split_q <= 1'b0;
            rsp_off_q   <= 2'b00;
            rsp_mask_q  <= 3'b000;
            cap_q       <= 32'h0000_0000;
            hold_q      <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rsp_split_q <= rsp_split_d;
            rsp_off_q   <= rsp_off_d;
            rsp_mask_q  <= rsp_mask_d;
            cap_q       <= cap_d;
            if (rvalid_q) begin
                hold_q <= load_data_s;
            end else begin
                hold_q <= hold_q;
            end
        end
    end

endmodule
